// File: rtl/ir_fusion_pkg.sv
// Shared types, default constants and the signed saturation helper for the
// IR heading-fusion pipeline.
package ir_fusion_pkg;

   typedef enum logic [1:0] {FILL, TRACK, HOLD} fusion_state_t;

   localparam logic [11:0] NOM_IR_DEF  = 12'h970;
   localparam int unsigned P_SHIFT_DEF = 5;
   localparam int unsigned D_SHIFT_DEF = 2;

   // Clamp a signed value into the range of a signed field of the given width.
   function automatic logic signed [31:0] sat_s(input logic signed [31:0] value,
                                                input int unsigned width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/ir_mavg.sv
// Moving-average history: circular buffer of 2^L signed samples with a
// running sum; clr (or rst) empties it back to all zeros.
module ir_mavg
   import ir_fusion_pkg::*;
#(
   parameter int unsigned W = 13,
   parameter int unsigned L = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  push,
   input  logic signed [W-1:0]   din,
   output logic signed [W+L-1:0] sum
);

   localparam int unsigned D  = 1 << L;
   localparam int unsigned PW = (L > 0) ? L : 1;

   logic signed [W-1:0] hist [D];
   logic [PW-1:0]       ptr;
   logic [PW-1:0]       ptr_nxt;

   always_comb begin
      ptr_nxt = (ptr == PW'(D - 1)) ? '0 : ptr + PW'(1);
   end

   // The slot about to be overwritten holds the oldest sample.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int unsigned i = 0; i < D; i++) hist[i] <= '0;
         ptr <= '0;
         sum <= '0;
      end else if (push) begin
         hist[ptr] <= din;
         ptr       <= ptr_nxt;
         sum       <= sum + (W+L)'(din) - (W+L)'(hist[ptr]);
      end
   end

endmodule

// File: rtl/ir_fusion_pipe.sv
// Pipelined IR wall-tracking heading correction with fill/hold sequencing.
// Define IR_SAT_CNT_EN to add the sticky 8-bit saturation counter output.
module ir_fusion_pipe
   import ir_fusion_pkg::*;
#(
   parameter int unsigned      IR_W      = 12,
   parameter int unsigned      HDNG_W    = 12,
   parameter logic [IR_W-1:0]  NOM_IR    = IR_W'(NOM_IR_DEF),
   parameter int unsigned      AVG_LOG2  = 2,
   parameter int unsigned      P_SHIFT   = P_SHIFT_DEF,
   parameter int unsigned      D_SHIFT   = D_SHIFT_DEF,
   parameter int unsigned      HOLD_SMPL = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     smpl_vld,
   input  logic [IR_W-1:0]          lft_IR,
   input  logic [IR_W-1:0]          rght_IR,
   input  logic                     lft_opn,
   input  logic                     rght_opn,
   input  logic                     en_fusion,
   input  logic signed [HDNG_W-1:0] dsrd_hdng,
   output logic signed [HDNG_W-1:0] dsrd_hdng_adj,
   output logic                     adj_vld,
   output logic                     fusion_actv
`ifdef IR_SAT_CNT_EN
   ,
   output logic [7:0]               sat_cnt
`endif
);

   localparam int unsigned EW = IR_W + 1;
   localparam int unsigned SW = EW + AVG_LOG2;
   localparam int unsigned D  = 1 << AVG_LOG2;

   logic signed [EW-1:0] lft_e, rght_e, nom_e, diff, err;
   always_comb begin
      lft_e  = $signed({1'b0, lft_IR});
      rght_e = $signed({1'b0, rght_IR});
      nom_e  = $signed({1'b0, NOM_IR});
      diff   = lft_e - rght_e;
      unique case ({lft_opn, rght_opn})
         2'b11:   err = '0;
         2'b10:   err = nom_e - rght_e;
         2'b01:   err = lft_e - nom_e;
         default: err = diff >>> 1;
      endcase
   end

   fusion_state_t state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [1:0]    cfg_q;
   logic          cfg_chg, push, clr, use_y;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (smpl_vld) cfg_q <= {lft_opn, rght_opn};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      push    = 1'b0;
      clr     = 1'b0;
      use_y   = 1'b0;
      cfg_chg = ({lft_opn, rght_opn} != cfg_q);
      if (smpl_vld) begin
         unique case (state_q)
            FILL: begin
               if (cfg_chg) begin
                  clr   = 1'b1;
                  cnt_d = '0;
               end else begin
                  push = 1'b1;
                  if (cnt_q == 8'(D - 1)) begin
                     state_d = TRACK;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
            TRACK: begin
               if (cfg_chg) begin
                  if (HOLD_SMPL <= 1) begin
                     state_d = FILL;
                     clr     = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     state_d = HOLD;
                     cnt_d   = 8'd1;
                  end
               end else begin
                  push  = 1'b1;
                  use_y = en_fusion;
               end
            end
            HOLD: begin
               if (cfg_chg) begin
                  cnt_d = 8'd1;
               end else if (cnt_q + 8'd1 >= 8'(HOLD_SMPL)) begin
                  state_d = FILL;
                  clr     = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: begin
               state_d = FILL;
               clr     = 1'b1;
               cnt_d   = '0;
            end
         endcase
      end
   end

   logic signed [SW-1:0] sum, f_cur, fprev;

   ir_mavg #(.W(EW), .L(AVG_LOG2)) u_mavg (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .push (push),
      .din  (err),
      .sum  (sum)
   );

   assign f_cur = sum >>> AVG_LOG2;

   // f_prev captures the filter value just before each push, so one cycle
   // later f_cur - fprev is the derivative belonging to that same sample.
   logic                     vld1, use_y1;
   logic signed [HDNG_W-1:0] hdng1;
   always_ff @(posedge clk) begin
      if (rst) begin
         vld1   <= 1'b0;
         use_y1 <= 1'b0;
         hdng1  <= '0;
         fprev  <= '0;
      end else begin
         vld1 <= smpl_vld;
         if (smpl_vld) begin
            use_y1 <= use_y;
            hdng1  <= dsrd_hdng;
         end
         if (clr)       fprev <= '0;
         else if (push) fprev <= f_cur;
      end
   end

   logic signed [31:0]       f32, d32, dterm, c_raw, c_val, y_raw;
   logic signed [HDNG_W-1:0] y_val;
   always_comb begin
      f32   = 32'(f_cur);
      d32   = f32 - 32'(fprev);
      dterm = sat_s(d32 <<< D_SHIFT, HDNG_W);
      c_raw = ((f32 >>> P_SHIFT) + dterm) >>> 1;
      c_val = sat_s(c_raw, HDNG_W);
      y_raw = 32'(hdng1) + c_val;
      y_val = HDNG_W'(sat_s(y_raw, HDNG_W));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dsrd_hdng_adj <= '0;
         adj_vld       <= 1'b0;
         fusion_actv   <= 1'b0;
      end else begin
         adj_vld <= vld1;
         if (vld1) begin
            dsrd_hdng_adj <= use_y1 ? y_val : hdng1;
            fusion_actv   <= use_y1;
         end
      end
   end

`ifdef IR_SAT_CNT_EN
   logic sat_hit;
   always_comb begin
      sat_hit = vld1 && use_y1 &&
                ((dterm != (d32 <<< D_SHIFT)) || (c_val != c_raw) ||
                 (sat_s(y_raw, HDNG_W) != y_raw));
   end

   always_ff @(posedge clk) begin
      if (rst)                           sat_cnt <= '0;
      else if (sat_hit && sat_cnt != '1) sat_cnt <= sat_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_ir_fusion_pipe.sv
// Self-checking bench for ir_fusion_pipe: directed scenarios plus random
// strobes, compared cycle by cycle against a sample-level reference model.
module tb_ir_fusion_pipe;

   localparam int D      = 4;
   localparam int HOLD_N = 4;
   localparam int NOM    = 'h970;
   localparam int M_FILL = 0, M_TRACK = 1, M_HOLD = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1, smpl_vld = 1'b0, lft_opn = 1'b0, rght_opn = 1'b0, en_fusion = 1'b0;
   logic [11:0]       lft_IR = '0, rght_IR = '0;
   logic signed [11:0] dsrd_hdng = '0;
   logic signed [11:0] dsrd_hdng_adj;
   logic              adj_vld, fusion_actv;
`ifdef IR_SAT_CNT_EN
   logic [7:0]        sat_cnt;
`endif

   ir_fusion_pipe dut (
      .clk           (clk),
      .rst           (rst),
      .smpl_vld      (smpl_vld),
      .lft_IR        (lft_IR),
      .rght_IR       (rght_IR),
      .lft_opn       (lft_opn),
      .rght_opn      (rght_opn),
      .en_fusion     (en_fusion),
      .dsrd_hdng     (dsrd_hdng),
      .dsrd_hdng_adj (dsrd_hdng_adj),
      .adj_vld       (adj_vld),
      .fusion_actv   (fusion_actv)
`ifdef IR_SAT_CNT_EN
      ,
      .sat_cnt       (sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state (sample level)
   int         win [D];
   int         mode, fill_n, hold_n;
   logic [1:0] prev_cfg;
   bit         pend_v, pend_a, pend_s, exp_v, exp_a;
   int         pend_y, exp_y, exp_sat;

   function automatic int fdiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && ((a < 0) != (b < 0))) q--;
      return q;
   endfunction

   function automatic int clamp(input int v);
      if (v > 2047)  return 2047;
      if (v < -2048) return -2048;
      return v;
   endfunction

   function automatic int favg();
      int s;
      s = 0;
      for (int i = 0; i < D; i++) s += win[i];
      return fdiv(s, D);
   endfunction

   task automatic win_clear();
      for (int i = 0; i < D; i++) win[i] = 0;
   endtask

   task automatic win_push(input int e);
      for (int i = 0; i < D - 1; i++) win[i] = win[i+1];
      win[D-1] = e;
   endtask

   task automatic model_reset();
      win_clear();
      mode = M_FILL; fill_n = 0; hold_n = 0; prev_cfg = 2'b00;
   endtask

   task automatic model_sample(output int y, output bit act, output bit sat);
      int l, r, h, e, fb, fa, d, dt, c_raw, c, y_raw;
      bit chg;
      l = int'(lft_IR); r = int'(rght_IR); h = int'(dsrd_hdng);
      if (lft_opn && rght_opn) e = 0;
      else if (lft_opn)        e = NOM - r;
      else if (rght_opn)       e = l - NOM;
      else                     e = fdiv(l - r, 2);
      chg = ({lft_opn, rght_opn} != prev_cfg);
      prev_cfg = {lft_opn, rght_opn};
      y = h; act = 0; sat = 0;
      case (mode)
         M_FILL: begin
            if (chg) begin
               win_clear(); fill_n = 0;
            end else begin
               win_push(e); fill_n++;
               if (fill_n == D) mode = M_TRACK;
            end
         end
         M_TRACK: begin
            if (chg) begin
               mode = M_HOLD; hold_n = 1;
            end else begin
               fb = favg(); win_push(e); fa = favg();
               d = fa - fb;
               dt = clamp(d * 4);
               c_raw = fdiv(fdiv(fa, 32) + dt, 2);
               c = clamp(c_raw);
               y_raw = h + c;
               if (en_fusion) begin
                  y = clamp(y_raw); act = 1;
                  sat = (dt != d * 4) || (c != c_raw) || (clamp(y_raw) != y_raw);
               end
            end
         end
         default: begin
            if (chg) hold_n = 1;
            else     hold_n++;
            if (hold_n >= HOLD_N) begin
               win_clear(); mode = M_FILL; fill_n = 0;
            end
         end
      endcase
   endtask

   task automatic drive(input bit r, input bit v, input bit lo, input bit ro, input bit en,
                        input int l, input int rr, input int h);
      bit nv, na, ns;
      int ny;
      @(negedge clk);
      rst = r; smpl_vld = v; lft_opn = lo; rght_opn = ro; en_fusion = en;
      lft_IR = 12'(l); rght_IR = 12'(rr); dsrd_hdng = 12'(h);
      nv = 0; na = 0; ns = 0; ny = 0;
      if (r) model_reset();
      else if (v) begin
         model_sample(ny, na, ns);
         nv = 1;
      end
      @(posedge clk); #1;
      if (r) begin
         exp_v = 0; exp_y = 0; exp_a = 0; exp_sat = 0;
      end else begin
         exp_v = pend_v;
         if (pend_v) begin
            exp_y = pend_y; exp_a = pend_a;
            if (pend_s && exp_sat < 255) exp_sat++;
         end
      end
      pend_v = nv; pend_y = ny; pend_a = na; pend_s = ns;
      chk("adj_vld", int'(adj_vld), int'(exp_v));
      chk("adj", int'(dsrd_hdng_adj), exp_y);
      chk("actv", int'(fusion_actv), int'(exp_a));
`ifdef IR_SAT_CNT_EN
      chk("sat_cnt", int'(sat_cnt), exp_sat);
`endif
   endtask

   initial begin
      bit r, v, en;
      int l, rr, h;
      logic lo, ro;
      model_reset();
      pend_v = 0; pend_a = 0; pend_s = 0; pend_y = 0;
      exp_v = 0; exp_a = 0; exp_y = 0; exp_sat = 0;

      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 1, 'hA70, 'h870, 'h100);
      chk("rst_adj", int'(dsrd_hdng_adj), 0);

      // Fill with both walls, fifth sample fuses
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 1, 'hA70, 'h870, 'h100);
      drive(0, 0, 0, 0, 1, 'hA70, 'h870, 'h100);
      chk("tp1_adj", int'(dsrd_hdng_adj), 'h104);
      chk("tp1_actv", int'(fusion_actv), 1);
      drive(0, 0, 0, 0, 1, 'hA70, 'h870, 'h100);
      chk("tp1_vld_drop", int'(adj_vld), 0);

      // Right wall vanishes: 4 hold + 4 fill, ninth fuses with c=2
      for (int i = 0; i < 9; i++) drive(0, 1, 0, 1, 1, 'h9F0, 'h870, 'h100);
      drive(0, 0, 0, 1, 1, 'h9F0, 'h870, 'h100);
      chk("tp2_adj", int'(dsrd_hdng_adj), 'h102);

      // Back to both walls then heading near positive limit
      for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 1, 'hA70, 'h870, 'h100);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 1, 'hA70, 'h870, 'h7FE);
      drive(0, 0, 0, 0, 1, 'hA70, 'h870, 'h7FE);
      chk("tp3_sat", int'(dsrd_hdng_adj), 'h7FF);

      // Fusion disabled in TRACK, then re-enabled
      for (int i = 0; i < 2; i++) drive(0, 1, 0, 0, 0, 'hA70, 'h870, 'h050);
      drive(0, 0, 0, 0, 0, 'hA70, 'h870, 'h050);
      chk("tp4_adj", int'(dsrd_hdng_adj), 'h050);
      chk("tp4_actv", int'(fusion_actv), 0);
      drive(0, 1, 0, 0, 1, 'hA70, 'h870, 'h100);
      drive(0, 0, 0, 0, 1, 'hA70, 'h870, 'h100);
      chk("tp4_track", int'(dsrd_hdng_adj), 'h104);

      // Reset with samples in flight
      for (int i = 0; i < 2; i++) drive(0, 1, 0, 0, 1, 'hA70, 'h870, 'h100);
      drive(1, 1, 0, 0, 1, 'hA70, 'h870, 'h100);
      drive(0, 0, 0, 0, 1, 'hA70, 'h870, 'h100);
      chk("tp5_vld", int'(adj_vld), 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 1, 'hA70, 'h870, 'h100);
      drive(0, 0, 0, 0, 1, 'hA70, 'h870, 'h100);
      chk("tp5_fill", int'(fusion_actv), 0);
      drive(0, 1, 0, 0, 1, 'hA70, 'h870, 'h100);
      drive(0, 0, 0, 0, 1, 'hA70, 'h870, 'h100);
      chk("tp5_fuse", int'(fusion_actv), 1);

      // Error step 0 -> 256: derivative kick then settles to c=4
      drive(1, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 1, 'h900, 'h900, 0);
      drive(0, 1, 0, 0, 1, 'hB00, 'h900, 0);
      drive(0, 0, 0, 0, 1, 'hB00, 'h900, 0);
      chk("tp6_kick", int'(dsrd_hdng_adj), 129);
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 1, 'hB00, 'h900, 0);
      drive(0, 0, 0, 0, 1, 'hB00, 'h900, 0);
      chk("tp6_settle", int'(dsrd_hdng_adj), 4);

      // Randomized traffic
      lo = 1'b0; ro = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         r  = ($urandom_range(0, 199) == 0);
         v  = ($urandom_range(0, 9) < 7);
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 24) == 0) begin
            lo = 1'($urandom);
            ro = 1'($urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            l  = int'($urandom_range(0, 4095));
            rr = int'($urandom_range(0, 4095));
         end else begin
            l  = NOM + int'($urandom_range(0, 600)) - 300;
            rr = NOM + int'($urandom_range(0, 600)) - 300;
         end
         if ($urandom_range(0, 3) == 0)
            h = ($urandom_range(0, 1) == 0) ? 2047 - int'($urandom_range(0, 8))
                                             : -2048 + int'($urandom_range(0, 8));
         else
            h = int'($urandom_range(0, 4095)) - 2048;
         drive(r, v, lo, ro, en, l, rr, h);
      end
      drive(0, 0, lo, ro, 1, 0, 0, 0);
      drive(0, 0, lo, ro, 1, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
